// File: rtl/sad_min_search_if.sv
// Handshake and data bundle between the block-matching source and sad_min_search.
interface sad_min_search_if #(
  parameter int WORD_WIDTH = 8,
  parameter int MV_WIDTH   = 5
) ();
  logic                          start;
  logic [16*WORD_WIDTH-1:0]      cur_blk;
  logic [16*WORD_WIDTH-1:0]      cand_blk;
  logic                          cand_valid;
  logic signed [MV_WIDTH-1:0]    cand_mvx;
  logic signed [MV_WIDTH-1:0]    cand_mvy;
  logic                          busy;
  logic                          done;
  logic [WORD_WIDTH+3:0]         best_sad;
  logic signed [MV_WIDTH-1:0]    best_mvx;
  logic signed [MV_WIDTH-1:0]    best_mvy;

  modport master (
    output start, cur_blk, cand_blk, cand_valid, cand_mvx, cand_mvy,
    input  busy, done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, cur_blk, cand_blk, cand_valid, cand_mvx, cand_mvy,
    output busy, done, best_sad, best_mvx, best_mvy
  );
endinterface

// File: rtl/sad_min_search.sv
// Full-search SAD minimum finder: captures a 4x4 current block, scores one
// candidate per cycle through an abs-diff / row-sum / total pipeline and keeps
// the earliest candidate with the smallest SAD together with its motion vector.
module sad_min_search #(
  parameter int WORD_WIDTH = 8,
  parameter int MV_WIDTH   = 5,
  parameter int NUM_CAND   = 81
) (
  input  logic            clk,
  input  logic            rst_n,
  sad_min_search_if.slave bus
);
  localparam int BLK_W = 16 * WORD_WIDTH;
  localparam int ROW_W = WORD_WIDTH + 2;
  localparam int SAD_W = WORD_WIDTH + 4;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_busy;
  logic   w_done;

  logic                       w_accept;
  logic                       w_start;
  logic [BLK_W-1:0]           r_cur;
  logic [CNT_W-1:0]           r_cnt;

  logic [BLK_W-1:0]           r_cand_p0;
  logic signed [MV_WIDTH-1:0] r_mvx_p0, r_mvy_p0;
  logic                       r_vld_p0;

  logic [WORD_WIDTH-1:0]      r_ad_p1 [16];
  logic signed [MV_WIDTH-1:0] r_mvx_p1, r_mvy_p1;
  logic                       r_vld_p1;

  logic [ROW_W-1:0]           r_row_p2 [4];
  logic signed [MV_WIDTH-1:0] r_mvx_p2, r_mvy_p2;
  logic                       r_vld_p2;

  logic [SAD_W-1:0]           r_sad_p3;
  logic signed [MV_WIDTH-1:0] r_mvx_p3, r_mvy_p3;
  logic                       r_vld_p3;

  logic [SAD_W-1:0]           r_best_sad;
  logic signed [MV_WIDTH-1:0] r_best_mvx, r_best_mvy;

  // Unsigned absolute difference; never exceeds WORD_WIDTH bits.
  function automatic logic [WORD_WIDTH-1:0] abs_diff(
    input logic [WORD_WIDTH-1:0] a,
    input logic [WORD_WIDTH-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Sum of four pixel differences widened first so the carry is kept.
  function automatic logic [ROW_W-1:0] row_sum(
    input logic [WORD_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] b,
    input logic [WORD_WIDTH-1:0] c, input logic [WORD_WIDTH-1:0] d
  );
    return ROW_W'(a) + ROW_W'(b) + ROW_W'(c) + ROW_W'(d);
  endfunction

  assign w_accept = (r_state == S_RUN) && bus.cand_valid;
  assign w_start  = (r_state == S_IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs. In DRAIN the stage-3 compare lands on
  // the same edge the upstream valids are seen empty, so DONE coincides with
  // best_* becoming final.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.cand_valid && (r_cnt == LAST_IDX)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!(r_vld_p0 || r_vld_p1 || r_vld_p2)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Current block capture and accepted-candidate counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_cur <= bus.cur_blk;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Valid bits travelling alongside the pipeline data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // Datapath registers; contents are qualified by the valid bits only.
  always_ff @(posedge clk) begin
    // p0: accepted candidate and its vector
    if (w_accept) begin
      r_cand_p0 <= bus.cand_blk;
      r_mvx_p0  <= bus.cand_mvx;
      r_mvy_p0  <= bus.cand_mvy;
    end
    // p1: per-pixel absolute differences against the captured block
    for (int i = 0; i < 16; i++) begin
      r_ad_p1[i] <= abs_diff(r_cand_p0[(15-i)*WORD_WIDTH +: WORD_WIDTH],
                             r_cur[(15-i)*WORD_WIDTH +: WORD_WIDTH]);
    end
    r_mvx_p1 <= r_mvx_p0;
    r_mvy_p1 <= r_mvy_p0;
    // p2: row sums
    for (int r = 0; r < 4; r++) begin
      r_row_p2[r] <= row_sum(r_ad_p1[4*r], r_ad_p1[4*r+1], r_ad_p1[4*r+2], r_ad_p1[4*r+3]);
    end
    r_mvx_p2 <= r_mvx_p1;
    r_mvy_p2 <= r_mvy_p1;
    // p3: full SAD
    r_sad_p3 <= SAD_W'(r_row_p2[0]) + SAD_W'(r_row_p2[1]) +
                SAD_W'(r_row_p2[2]) + SAD_W'(r_row_p2[3]);
    r_mvx_p3 <= r_mvx_p2;
    r_mvy_p3 <= r_mvy_p2;
  end

  // Running minimum; strict less-than keeps the earliest candidate on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_best_sad <= '0;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else if (w_start) begin
      r_best_sad <= '1;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else if (r_vld_p3 && (r_sad_p3 < r_best_sad)) begin
      r_best_sad <= r_sad_p3;
      r_best_mvx <= r_mvx_p3;
      r_best_mvy <= r_mvy_p3;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.best_sad = r_best_sad;
  assign bus.best_mvx = r_best_mvx;
  assign bus.best_mvy = r_best_mvy;
endmodule

// File: tb/tb_sad_min_search.sv
// Scoreboard bench for sad_min_search: the stimulus process queues expected
// per-candidate SADs and per-search results; monitors pop and compare.
module tb_sad_min_search;
  localparam int W  = 8;
  localparam int MV = 5;
  localparam int NC = 81;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sad_min_search_if #(.WORD_WIDTH(W), .MV_WIDTH(MV)) bus ();
  sad_min_search #(.WORD_WIDTH(W), .MV_WIDTH(MV), .NUM_CAND(NC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { int sad; int mx; int my; int dcyc; } exp_t;
  exp_t expq[$];
  int   sadq[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] cur;
  logic [127:0] cb [NC];
  int mx [NC];
  int my [NC];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_sad(input logic [127:0] a, input logic [127:0] b);
    int s, x, y;
    s = 0;
    for (int p = 0; p < 16; p++) begin
      x = int'(a[p*8 +: 8]);
      y = int'(b[p*8 +: 8]);
      s += (x > y) ? (x - y) : (y - x);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic grid_mv();
    for (int i = 0; i < NC; i++) begin
      mx[i] = (i % 9) - 4;
      my[i] = (i / 9) - 4;
    end
  endtask

  task automatic rnd_case();
    cur = rnd_blk();
    for (int i = 0; i < NC; i++) begin
      cb[i] = rnd_blk();
      mx[i] = int'($urandom_range(0, 8)) - 4;
      my[i] = int'($urandom_range(0, 8)) - 4;
    end
  endtask

  // gap: max idle cycles between candidates (1 with alt=1 means strict toggle)
  task automatic run_search(input int gap, input bit alt, input bit disturb,
                            input bit extra_valid, input bit abort);
    int best, bx, by, s, lastc, k, g;
    best = 4095; bx = 0; by = 0; lastc = 0;
    for (int i = 0; i < NC; i++) begin
      s = ref_sad(cur, cb[i]);
      if (s < best) begin best = s; bx = mx[i]; by = my[i]; end
    end
    bus.cur_blk = cur;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    chk("rearm_best_sad", int'(bus.best_sad), 4095);
    if (disturb) bus.cur_blk = ~cur;
    for (int i = 0; i < NC; i++) begin
      g = alt ? gap : int'($urandom_range(0, gap));
      for (int j = 0; j < g; j++) begin
        bus.cand_valid = 1'b0;
        bus.cand_blk   = rnd_blk();
        tick();
      end
      bus.cand_valid = 1'b1;
      bus.cand_blk   = cb[i];
      bus.cand_mvx   = MV'(mx[i]);
      bus.cand_mvy   = MV'(my[i]);
      sadq.push_back(ref_sad(cur, cb[i]));
      if (disturb && i == 10) begin
        bus.start   = 1'b1;
        bus.cur_blk = rnd_blk();
      end
      tick();
      bus.start = 1'b0;
      lastc = cyc;
    end
    bus.cand_valid = extra_valid;
    bus.cand_blk   = rnd_blk();
    if (abort) begin
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.cand_valid = 1'b0;
      sadq.delete();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_best_sad", int'(bus.best_sad), 0);
      chk("rst_best_mvx", int'($signed(bus.best_mvx)), 0);
      chk("rst_best_mvy", int'($signed(bus.best_mvy)), 0);
      repeat (10) tick();
      chk("rst_still_idle", int'(bus.busy), 0);
      return;
    end
    expq.push_back('{sad: best, mx: bx, my: by, dcyc: lastc + 4});
    k = 0;
    while (bus.busy && k < 40) begin
      tick();
      k++;
    end
    bus.cand_valid = 1'b0;
    chk("drain_timeout_busy", int'(bus.busy), 0);
    chk("done_seen", expq.size(), 0);
    expq.delete();
    chk("hold_best_sad", int'(bus.best_sad), best);
  endtask

  // Per-candidate SAD at the final pipeline stage.
  always @(negedge clk) begin
    if (dut.r_vld_p3) begin
      if (sadq.size() == 0) begin
        checks++; failures++;
        $display("FAIL stage3_unexpected: got sad %0d with no candidate pending", dut.r_sad_p3);
      end else begin
        chk("stage3_sad", int'(dut.r_sad_p3), sadq.pop_front());
      end
    end
  end

  // Search result on the done pulse.
  always @(negedge clk) begin
    if (bus.done) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        mon_e = expq.pop_front();
        chk("best_sad", int'(bus.best_sad), mon_e.sad);
        chk("best_mvx", int'($signed(bus.best_mvx)), mon_e.mx);
        chk("best_mvy", int'($signed(bus.best_mvy)), mon_e.my);
        chk("done_cycle", cyc, mon_e.dcyc);
        chk("busy_at_done", int'(bus.busy), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.cur_blk = '0; bus.cand_blk = '0;
    bus.cand_valid = 1'b0; bus.cand_mvx = '0; bus.cand_mvy = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_best_sad", int'(bus.best_sad), 0);
    chk("reset_best_mvx", int'($signed(bus.best_mvx)), 0);
    tick();

    // exact match at candidate 40, mv (0,0)
    grid_mv();
    cur = {16{8'h10}};
    for (int i = 0; i < NC; i++) cb[i] = {16{8'h20}};
    cb[40] = {16{8'h10}};
    run_search(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // tie between #3 and #7, earliest wins
    for (int i = 0; i < NC; i++) cb[i] = {16{8'h12}};
    cb[3] = {16{8'h11}}; mx[3] = -4; my[3] = -2;
    cb[7] = {16{8'h0F}}; mx[7] = 1;  my[7] = 1;
    run_search(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // max width: 4080 everywhere, 3825 at #80
    grid_mv();
    cur = '0;
    for (int i = 0; i < NC; i++) cb[i] = {16{8'hFF}};
    cb[80][(15-5)*8 +: 8] = 8'h00;
    run_search(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // strictly toggling cand_valid plus a valid held through DRAIN
    rnd_case();
    run_search(1, 1'b1, 1'b0, 1'b1, 1'b0);

    // start mid-RUN and cur_blk change after capture
    rnd_case();
    run_search(0, 1'b0, 1'b1, 1'b0, 1'b0);

    // random searches with random gaps, issued back to back
    for (int t = 0; t < 3; t++) begin
      rnd_case();
      run_search(3, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // reset during DRAIN, then a clean search afterwards
    rnd_case();
    run_search(0, 1'b0, 1'b0, 1'b0, 1'b1);
    rnd_case();
    run_search(2, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
